// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one unified data memory between the fetch port (I) and the load/store port (D).
// Define MEM_ARB_PERF_EN to add grant and conflict performance counters.

module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_conflicts
`endif
);

  // state  | meaning
  // IDLE   | no access in flight; arbitrate between i_req and d_req
  // ACCESS | memory access in flight; cnt counts down the read latency
  // RESP   | ack pulse to the owning port, then back to IDLE

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  logic       last_owner;
  logic       acc_wr;
  logic [3:0] cnt;

  logic grant_any;
  logic grant_d;

  // On a tie, the port that did not win last time gets the grant.
  always_comb begin
    grant_any = 1'b0;
    grant_d   = 1'b0;
    grant_any = i_req | d_req;
    grant_d   = d_req & (~i_req | ~last_owner);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b0;
      acc_wr     <= 1'b0;
      cnt        <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            owner      <= grant_d;
            last_owner <= grant_d;
            acc_wr     <= grant_d & d_wr;
            mem_wr     <= grant_d & d_wr;
            mem_addr   <= grant_d ? d_addr : i_addr;
            mem_wdata  <= grant_d ? d_wdata : '0;
            cnt        <= CNT_INIT;
          end
        end
        ACCESS: begin
          // The write strobe is a single-cycle pulse at the start of the access.
          mem_wr <= 1'b0;
          if (cnt == 4'd0) begin
            state <= RESP;
            if (owner) begin
              d_ack <= 1'b1;
              if (!acc_wr) d_rdata <= mem_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else if (state == IDLE) begin
      if (grant_any && grant_d)  perf_d_grants  <= perf_d_grants + 32'd1;
      if (grant_any && !grant_d) perf_i_grants  <= perf_i_grants + 32'd1;
      if (i_req && d_req)        perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 (a_*) and one with MEM_LAT=4 (b_*).
// Counter checks are compiled in when MEM_ARB_PERF_EN is defined.

module tb_mem_port_arbiter;

  logic clk;

  logic        a_rst, a_i_req, a_i_ack, a_d_req, a_d_wr, a_d_ack, a_mem_wr, a_busy, a_owner;
  logic [63:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [63:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_rst, b_i_req, b_i_ack, b_d_req, b_d_wr, b_d_ack, b_mem_wr, b_busy, b_owner;
  logic [63:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] a_perf_i, a_perf_d, a_perf_c;
  logic [31:0] b_perf_i, b_perf_d, b_perf_c;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(a_rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ack(a_i_ack), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_wr(a_d_wr), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wr(a_mem_wr),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
`ifdef MEM_ARB_PERF_EN
    , .perf_i_grants(a_perf_i), .perf_d_grants(a_perf_d), .perf_conflicts(a_perf_c)
`endif
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(4)) dut_b (
    .clk(clk), .rst(b_rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_wr(b_d_wr), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wr(b_mem_wr),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
`ifdef MEM_ARB_PERF_EN
    , .perf_i_grants(b_perf_i), .perf_d_grants(b_perf_d), .perf_conflicts(b_perf_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] exp_data;
    logic        exp_own;

    a_rst = 1'b1; a_i_req = 1'b0; a_i_addr = '0; a_d_req = 1'b0; a_d_wr = 1'b0;
    a_d_addr = '0; a_d_wdata = '0; a_mem_rdata = '0;
    b_rst = 1'b1; b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_wr = 1'b0;
    b_d_addr = '0; b_d_wdata = '0; b_mem_rdata = '0;
    tick();
    tick();

    chk("rst_busy",     64'(a_busy),   64'd0);
    chk("rst_owner",    64'(a_owner),  64'd0);
    chk("rst_mem_wr",   64'(a_mem_wr), 64'd0);
    chk("rst_mem_addr", a_mem_addr,    64'd0);
    chk("rst_acks",     64'({a_i_ack, a_d_ack}), 64'd0);
    chk("rst_rdata",    a_i_rdata | a_d_rdata,   64'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();

    // fetch, MEM_LAT=1
    a_i_req = 1'b1; a_i_addr = 64'h40; a_mem_rdata = 64'h0000_0000_00A0_0093;
    tick();
    chk("f_mem_addr", a_mem_addr, 64'h40);
    chk("f_busy",     64'(a_busy),  64'd1);
    chk("f_owner",    64'(a_owner), 64'd0);
    chk("f_ack_c1",   64'(a_i_ack), 64'd0);
    tick();
    chk("f_i_ack",    64'(a_i_ack), 64'd1);
    chk("f_d_ack",    64'(a_d_ack), 64'd0);
    chk("f_i_rdata",  a_i_rdata, 64'h00A0_0093);
    a_i_req = 1'b0;
    tick();
    chk("f_ack_drop", 64'(a_i_ack), 64'd0);
    chk("f_idle",     64'(a_busy),  64'd0);

    // store, MEM_LAT=1
    a_d_req = 1'b1; a_d_wr = 1'b1; a_d_addr = 64'h100; a_d_wdata = 64'hDEAD_BEEF;
    a_mem_rdata = 64'hFFFF_0000_1234_5678;
    tick();
    chk("s_mem_wr",    64'(a_mem_wr), 64'd1);
    chk("s_mem_addr",  a_mem_addr,    64'h100);
    chk("s_mem_wdata", a_mem_wdata,   64'hDEAD_BEEF);
    chk("s_owner",     64'(a_owner),  64'd1);
    tick();
    chk("s_mem_wr_c2", 64'(a_mem_wr), 64'd0);
    chk("s_d_ack",     64'(a_d_ack),  64'd1);
    chk("s_i_ack",     64'(a_i_ack),  64'd0);
    chk("s_d_rdata",   a_d_rdata,     64'd0);
    chk("s_i_rdata",   a_i_rdata,     64'h00A0_0093);
    a_d_req = 1'b0; a_d_wr = 1'b0;
    tick();
    chk("s_ack_drop",  64'(a_d_ack),  64'd0);

    // reset clears rdata, then both ports request continuously
    a_rst = 1'b1;
    tick();
    chk("rst2_i_rdata", a_i_rdata, 64'd0);
    a_rst = 1'b0;
    a_i_req = 1'b1; a_i_addr = 64'h8;
    a_d_req = 1'b1; a_d_addr = 64'h10; a_d_wr = 1'b0;
    for (int g = 0; g < 4; g++) begin
      exp_own  = (g % 2 == 0);
      exp_data = 64'h1000 + 64'(g);
      a_mem_rdata = exp_data;
      tick();
      chk("rr_owner",    64'(a_owner), 64'(exp_own));
      chk("rr_mem_addr", a_mem_addr,   exp_own ? 64'h10 : 64'h8);
      tick();
      chk("rr_d_ack",    64'(a_d_ack), 64'(exp_own));
      chk("rr_i_ack",    64'(a_i_ack), 64'(!exp_own));
      if (exp_own) chk("rr_d_rdata", a_d_rdata, exp_data);
      else         chk("rr_i_rdata", a_i_rdata, exp_data);
      if (g == 3) begin
        a_i_req = 1'b0;
        a_d_req = 1'b0;
      end
      tick();
      chk("rr_idle", 64'(a_busy), 64'd0);
    end
`ifdef MEM_ARB_PERF_EN
    chk("perf_d_grants",  64'(a_perf_d), 64'd2);
    chk("perf_i_grants",  64'(a_perf_i), 64'd2);
    chk("perf_conflicts", 64'(a_perf_c), 64'd4);
`endif

    // load, MEM_LAT=4; rdata only becomes correct in the last ACCESS cycle
    b_d_req = 1'b1; b_d_wr = 1'b0; b_d_addr = 64'h200; b_mem_rdata = 64'hBAD;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("l4_mem_addr", b_mem_addr,    64'h200);
      chk("l4_no_ack",   64'(b_d_ack),  64'd0);
      chk("l4_busy",     64'(b_busy),   64'd1);
      if (c == 4) b_mem_rdata = 64'h00C0_FFEE_0000_0200;
    end
    tick();
    chk("l4_d_ack",   64'(b_d_ack), 64'd1);
    chk("l4_d_rdata", b_d_rdata,    64'h00C0_FFEE_0000_0200);
    b_d_req = 1'b0;
    tick();
    chk("l4_ack_drop", 64'(b_d_ack), 64'd0);
    chk("l4_idle",     64'(b_busy),  64'd0);

    // store aborted by reset in its second ACCESS cycle
    b_d_req = 1'b1; b_d_wr = 1'b1; b_d_addr = 64'h300; b_d_wdata = 64'h55;
    tick();
    chk("ab_mem_wr_c1", 64'(b_mem_wr), 64'd1);
    tick();
    chk("ab_mem_wr_c2", 64'(b_mem_wr), 64'd0);
    chk("ab_busy_c2",   64'(b_busy),   64'd1);
    b_rst = 1'b1;
    tick();
    chk("ab_busy",      64'(b_busy),   64'd0);
    chk("ab_mem_wr",    64'(b_mem_wr), 64'd0);
    chk("ab_mem_addr",  b_mem_addr,    64'd0);
    chk("ab_mem_wdata", b_mem_wdata,   64'd0);
    chk("ab_owner",     64'(b_owner),  64'd0);
    chk("ab_d_rdata",   b_d_rdata,     64'd0);
    chk("ab_d_ack",     64'(b_d_ack),  64'd0);
    b_rst = 1'b0;
    b_d_req = 1'b0; b_d_wr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("ab_no_late_ack", 64'({b_d_ack, b_i_ack}), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
